// File: rtl/bus_pkg.sv
// Shared bus definitions: response codes, HADDR field positions and the master state set.
package bus_pkg;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam int HA_TRANS    = 15;
  localparam int HA_SLV_MSB  = 14;
  localparam int HA_SLV_LSB  = 13;
  localparam int HA_WR       = 12;
  localparam int HA_ADDR_MSB = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSREQ,
    ST_ADDR,
    ST_DATA,
    ST_SPLITW,
    ST_DONE
  } mst_state_t;

  function automatic logic [15:0] haddr_pack(input logic trans, input logic [1:0] slv,
                                             input logic wr, input logic [10:0] addr);
    logic [15:0] h;
    h = '0;
    h[HA_TRANS] = trans;
    h[HA_SLV_MSB:HA_SLV_LSB] = slv;
    h[HA_WR] = wr;
    h[HA_ADDR_MSB:0] = addr;
    return h;
  endfunction

endpackage

// File: rtl/bus_master_split.sv
// Single-transfer bus master: request, address, data with retry/split/timeout handling; U_DONE 1 cycle after the final response.
// HSPLIT release and the SPLITW state exist only when MASTER_SPLIT_EN is defined; otherwise SPLIT is reported as an error.
module bus_master_split
  import bus_pkg::*;
#(
  parameter logic [1:0] MASTER_ID = 2'd1,
  parameter int         RETRY_MAX = 4,
  parameter int         TIMEOUT   = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        U_START,
  input  logic        U_WRITE,
  input  logic [1:0]  U_SLV,
  input  logic [10:0] U_ADDR,
  input  logic [31:0] U_WDATA,
  input  logic        U_LOCK,
  output logic [31:0] U_RDATA,
  output logic        U_DONE,
  output logic        U_ERR,
  output logic        U_BUSY,
  output logic        HBUSREQ,
  input  logic        HGRANT,
  output logic [15:0] HADDR,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic [1:0]  HRESP,
  input  logic        HREADY,
  input  logic [1:0]  HSPLIT,
  output logic [1:0]  HMAS,
  output logic        MLOCK
);

  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  mst_state_t     state;
  logic           lat_wr;
  logic [1:0]     lat_slv;
  logic [10:0]    lat_addr;
  logic           lat_lock;
  logic [RW-1:0]  retry_cnt;
  logic [TW-1:0]  to_cnt;
  logic           rsp_fin;
  logic           rsp_err;

  assign HMAS = MASTER_ID;

`ifndef MASTER_SPLIT_EN
  logic unused_hsplit;
  assign unused_hsplit = ^HSPLIT;
`endif

  // Decode of the DATA-cycle response: does it end the transfer, and with which status.
  // HREADY is compared against 1 so that an undriven line counts as a wait state.
  always_comb begin
    rsp_fin = 1'b0;
    rsp_err = 1'b0;
    if (HRESP == HRESP_ERROR) begin
      rsp_fin = 1'b1;
      rsp_err = 1'b1;
    end else if (HRESP == HRESP_RETRY) begin
      rsp_fin = (retry_cnt == RW'(RETRY_MAX - 1));
      rsp_err = 1'b1;
    end else if (HRESP == HRESP_SPLIT) begin
`ifndef MASTER_SPLIT_EN
      rsp_fin = 1'b1;
      rsp_err = 1'b1;
`endif
    end else if (HREADY == 1'b1) begin
      rsp_fin = 1'b1;
    end else if (to_cnt == TW'(TIMEOUT - 1)) begin
      rsp_fin = 1'b1;
      rsp_err = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      HBUSREQ   <= 1'b0;
      HADDR     <= '0;
      HWDATA    <= '0;
      MLOCK     <= 1'b0;
      U_RDATA   <= '0;
      U_DONE    <= 1'b0;
      U_ERR     <= 1'b0;
      U_BUSY    <= 1'b0;
      retry_cnt <= '0;
      to_cnt    <= '0;
      lat_wr    <= 1'b0;
      lat_slv   <= '0;
      lat_addr  <= '0;
      lat_lock  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (U_START) begin
            lat_wr    <= U_WRITE;
            lat_slv   <= U_SLV;
            lat_addr  <= U_ADDR;
            lat_lock  <= U_LOCK;
            HWDATA    <= U_WDATA;
            HBUSREQ   <= 1'b1;
            MLOCK     <= U_LOCK;
            U_BUSY    <= 1'b1;
            retry_cnt <= '0;
            to_cnt    <= '0;
            state     <= ST_BUSREQ;
          end
        end
        ST_BUSREQ: begin
          HBUSREQ <= 1'b1;
          MLOCK   <= lat_lock;
          if (HGRANT) begin
            HADDR <= haddr_pack(1'b1, lat_slv, lat_wr, lat_addr);
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          HADDR[HA_TRANS] <= 1'b0;
          to_cnt          <= '0;
          state           <= ST_DATA;
        end
        ST_DATA: begin
          to_cnt <= '0;
          if (rsp_fin) begin
            if (!lat_wr && !rsp_err) U_RDATA <= HRDATA;
            HBUSREQ <= 1'b0;
            MLOCK   <= 1'b0;
            U_DONE  <= 1'b1;
            U_ERR   <= rsp_err;
            state   <= ST_DONE;
          end else if (HRESP == HRESP_RETRY) begin
            retry_cnt       <= retry_cnt + 1'b1;
            HADDR[HA_TRANS] <= 1'b1;
            state           <= ST_ADDR;
          end else if (HRESP == HRESP_SPLIT) begin
`ifdef MASTER_SPLIT_EN
            HBUSREQ <= 1'b0;
            MLOCK   <= 1'b0;
            state   <= ST_SPLITW;
`endif
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_SPLITW: begin
`ifdef MASTER_SPLIT_EN
          // The retry count survives the split so a slave cannot extend the retry budget.
          if ((HSPLIT == MASTER_ID) && (MASTER_ID != 2'd0)) begin
            HBUSREQ <= 1'b1;
            MLOCK   <= lat_lock;
            state   <= ST_BUSREQ;
          end
`else
          state <= ST_IDLE;
`endif
        end
        ST_DONE: begin
          U_DONE    <= 1'b0;
          U_BUSY    <= 1'b0;
          HBUSREQ   <= 1'b0;
          MLOCK     <= 1'b0;
          retry_cnt <= '0;
          to_cnt    <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_master_split.md
BUS_MASTER_SPLIT -- requirements
Module: bus_master_split

Interface
REQ-001 SHALL have parameter MASTER_ID, default 2'd1: master number driven on HMAS and matched against HSPLIT.
REQ-002 SHALL have parameter RETRY_MAX, default 4: the maximum number of RETRY responses per transfer.
REQ-003 SHALL have parameter TIMEOUT, default 16: the maximum number of DATA-state cycles without a valid response.
REQ-004 CLK  in  1  single clock; all logic on posedge CLK.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 U_START  in  1  user transfer request, sampled in IDLE only.
REQ-007 U_WRITE  in  1  1 = write, 0 = read.
REQ-008 U_SLV  in  2  target slave number.
REQ-009 U_ADDR  in  11  word address within the 2K slave.
REQ-010 U_WDATA  in  32  write data.
REQ-011 U_LOCK  in  1  locked transfer request; driven out on MLOCK.
REQ-012 U_RDATA  out  32  read result.
REQ-013 U_DONE  out  1  one-cycle completion pulse.
REQ-014 U_ERR  out  1  failure status, valid while U_DONE=1.
REQ-015 U_BUSY  out  1  high whenever the state is not IDLE.
REQ-016 HBUSREQ  out  1  bus request to the arbiter.
REQ-017 HGRANT  in  1  bus grant from the arbiter.
REQ-018 HADDR  out  16  address phase: [15]=TRANS start, [14:13]=slave, [12]=write, [11]=0, [10:0]=address.
REQ-019 HWDATA  out  32  write data.
REQ-020 HRDATA  in  32  read data.
REQ-021 HRESP  in  2  OKAY=00, ERROR=01, RETRY=10, SPLIT=11.
REQ-022 HREADY  in  1  slave ready; only a value of exactly 1 counts (z or x reads as not ready).
REQ-023 HSPLIT  in  2  split-release master number from the slave.
REQ-024 HMAS  out  2  always equal to MASTER_ID.
REQ-025 MLOCK  out  1  lock indication to the slave.

Function
REQ-026 States SHALL be IDLE, BUSREQ, ADDR, DATA, SPLITW and DONE.
REQ-027 IDLE SHALL latch U_WRITE, U_SLV, U_ADDR, U_WDATA and U_LOCK and go to BUSREQ when U_START=1; U_START outside IDLE SHALL be ignored.
REQ-028 BUSREQ SHALL hold HBUSREQ=1 and go to ADDR on the first cycle HGRANT=1; there is no timeout in BUSREQ.
REQ-029 ADDR SHALL drive HADDR with [15]=1 for exactly one cycle, then go to DATA.
REQ-030 DATA SHALL drive HADDR[15]=0 with the other fields held, and hold HWDATA at the latched value until DONE.
REQ-031 In DATA, HREADY=1 with OKAY SHALL go to DONE with U_ERR=0; on a read, U_RDATA SHALL capture HRDATA in that same cycle.
REQ-032 In DATA, ERROR SHALL go to DONE with U_ERR=1, whatever the HREADY value.
REQ-033 In DATA, RETRY SHALL increment the retry count and return to ADDR; reaching RETRY_MAX SHALL instead go to DONE with U_ERR=1.
REQ-034 In DATA, SPLIT SHALL drop HBUSREQ and go to SPLITW.
REQ-035 SPLITW SHALL wait until HSPLIT==MASTER_ID (nonzero), then go to BUSREQ and reissue the same transfer; the retry count is not cleared.
REQ-036 TIMEOUT consecutive DATA cycles with no qualifying response SHALL go to DONE with U_ERR=1.
REQ-037 DONE SHALL pulse U_DONE for one cycle, drop HBUSREQ and MLOCK, clear the retry and timeout counters, and go to IDLE.
REQ-038 Latency with HGRANT already high: U_START at cycle 0 gives BUSREQ at cycle 1, ADDR at cycle 2, DATA at cycle 3, and U_DONE at the cycle after the OKAY.
REQ-039 Loss of HGRANT during DATA SHALL be ignored; the transfer runs to completion.
REQ-040 HBUSREQ SHALL be 1 in BUSREQ, ADDR and DATA, and 0 otherwise; MLOCK SHALL follow the latched U_LOCK in BUSREQ through DATA.

Reset
REQ-041 RST=1 SHALL force state IDLE, HBUSREQ=0, HADDR=0, HWDATA=0, MLOCK=0, U_RDATA=0, U_DONE=0, U_ERR=0, U_BUSY=0 and all counters to 0.
REQ-042 Reset mid-transfer SHALL abort the transfer with no U_DONE pulse.

Configuration
REQ-043 Macro MASTER_SPLIT_EN defined SHALL compile in the SPLITW state and the HSPLIT comparison.
REQ-044 Without MASTER_SPLIT_EN, a SPLIT response SHALL be treated as ERROR (DONE, U_ERR=1), and HSPLIT SHALL be unused.

Structure
REQ-045 The shared package bus_pkg SHALL hold the HRESP codes, the HADDR bit positions (TRANS=15, SLV=14:13, WR=12, ADDR MSB=10) and the master state enumeration.
REQ-046 No sub-module is natural; the block SHALL be a single module.

Verification
REQ-047 Write with HGRANT=1 and slave OKAY at the first DATA cycle: U_ADDR=0x123, U_SLV=1, U_WDATA=0xDEADBEEF -> HADDR=0xB123 for one cycle, HWDATA=0xDEADBEEF, U_DONE at cycle 4, U_ERR=0.
REQ-048 Read where the slave returns HRDATA=0x5A5A5A5A with OKAY -> U_RDATA=0x5A5A5A5A, U_ERR=0.
REQ-049 Slave answers RETRY 4 times -> 4 ADDR phases, then U_DONE with U_ERR=1.
REQ-050 SPLIT, then HSPLIT=MASTER_ID after 5 cycles, then OKAY -> HBUSREQ low during the wait, transfer reissued, U_ERR=0; without MASTER_SPLIT_EN -> U_ERR=1 immediately.
REQ-051 HREADY held at z for 16 DATA cycles -> U_DONE with U_ERR=1.
REQ-052 RST asserted during DATA -> next cycle IDLE, all outputs at reset values, no U_DONE pulse.
